sal_cmd_sched: RTL

Channel-level DRAM command scheduler that sits between the per-bank controllers and the DDR2 command bus. Each cycle it collects ACT/RD/WR/PRE/REF requests from all bank controllers and grants at most one, subject to inter-bank channel timing (tRRD, tCCD, tWTR, tRTW). It then drives the granted command, bank and address onto a registered command output. Per-bank timing (tRCD, tRP, tRAS, tRFC, tRTP, tWTP) stays in the bank controllers; this block enforces only cross-bank constraints.

---
 rtl/sal_cmd_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sal_cmd_sched.sv
// Channel-level DDR2 command scheduler: grants at most one bank request per cycle
// under cross-bank timing (tRRD/tCCD/tWTR/tRTW) and registers the granted command.
module sal_cmd_sched #(
  parameter int NUM_BANKS = 4,
  parameter int RA_WIDTH  = 14,
  parameter int CA_WIDTH  = 10,
  parameter int T_WIDTH   = 4,
  localparam int BA_W     = $clog2(NUM_BANKS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BANKS-1:0]          act_req_i,
  input  logic [NUM_BANKS-1:0]          rd_req_i,
  input  logic [NUM_BANKS-1:0]          wr_req_i,
  input  logic [NUM_BANKS-1:0]          pre_req_i,
  input  logic [NUM_BANKS-1:0]          ref_req_i,
  input  logic [NUM_BANKS*RA_WIDTH-1:0] ra_i,
  input  logic [NUM_BANKS*CA_WIDTH-1:0] ca_i,
  output logic [NUM_BANKS-1:0]          act_gnt_o,
  output logic [NUM_BANKS-1:0]          rd_gnt_o,
  output logic [NUM_BANKS-1:0]          wr_gnt_o,
  output logic [NUM_BANKS-1:0]          pre_gnt_o,
  output logic [NUM_BANKS-1:0]          ref_gnt_o,
  input  logic [T_WIDTH-1:0]            t_rrd_i,
  input  logic [T_WIDTH-1:0]            t_ccd_i,
  input  logic [T_WIDTH-1:0]            t_wtr_i,
  input  logic [T_WIDTH-1:0]            t_rtw_i,
  input  logic                          stall_i,
  output logic                          cmd_valid_o,
  output logic [2:0]                    cmd_o,
  output logic [BA_W-1:0]               cmd_ba_o,
  output logic [RA_WIDTH-1:0]           cmd_addr_o
);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  logic [BA_W-1:0]      r_rr_ptr;
  logic [T_WIDTH-1:0]   r_rrd_cnt, r_ccd_cnt, r_wtr_cnt, r_rtw_cnt;

  logic [NUM_BANKS-1:0] w_rd_elig, w_wr_elig, w_rw_req, w_act_elig, w_cls_req, w_onehot;
  logic [2:0]           w_cmd;
  logic [BA_W-1:0]      w_bank;
  logic [RA_WIDTH-1:0]  w_addr;
  logic                 w_gnt;

  function automatic logic [BA_W-1:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                              input logic [BA_W-1:0] ptr);
    logic [BA_W-1:0] idx;
    logic            found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      idx = ptr + BA_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [T_WIDTH-1:0] ld_val(input logic [T_WIDTH-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  assign w_rd_elig  = rd_req_i  & {NUM_BANKS{(r_ccd_cnt == '0) && (r_wtr_cnt == '0)}};
  assign w_wr_elig  = wr_req_i  & {NUM_BANKS{(r_ccd_cnt == '0) && (r_rtw_cnt == '0)}};
  assign w_rw_req   = w_rd_elig | w_wr_elig;
  assign w_act_elig = act_req_i & {NUM_BANKS{r_rrd_cnt == '0}};

  // RD and WR share a class; the bank's own RD wins over its WR on a tie.
  always_comb begin
    w_cmd     = CMD_NOP;
    w_cls_req = '0;
    if (!rst && !stall_i) begin
      if (|ref_req_i) begin
        w_cmd     = CMD_REF;
        w_cls_req = ref_req_i;
      end else if (|w_rw_req) begin
        w_cmd     = CMD_RD;
        w_cls_req = w_rw_req;
      end else if (|w_act_elig) begin
        w_cmd     = CMD_ACT;
        w_cls_req = w_act_elig;
      end else if (|pre_req_i) begin
        w_cmd     = CMD_PRE;
        w_cls_req = pre_req_i;
      end
    end
    w_bank = rr_pick(w_cls_req, r_rr_ptr);
    if (w_cmd == CMD_RD && !w_rd_elig[w_bank]) w_cmd = CMD_WR;
  end

  always_comb begin
    case (w_cmd)
      CMD_ACT:         w_addr = ra_i[w_bank*RA_WIDTH +: RA_WIDTH];
      CMD_RD, CMD_WR:  w_addr = RA_WIDTH'(ca_i[w_bank*CA_WIDTH +: CA_WIDTH]);
      default:         w_addr = '0;
    endcase
  end

  assign w_gnt     = (w_cmd != CMD_NOP);
  assign w_onehot  = w_gnt ? (NUM_BANKS'(1) << w_bank) : '0;
  assign act_gnt_o = (w_cmd == CMD_ACT) ? w_onehot : '0;
  assign rd_gnt_o  = (w_cmd == CMD_RD)  ? w_onehot : '0;
  assign wr_gnt_o  = (w_cmd == CMD_WR)  ? w_onehot : '0;
  assign pre_gnt_o = (w_cmd == CMD_PRE) ? w_onehot : '0;
  assign ref_gnt_o = (w_cmd == CMD_REF) ? w_onehot : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rrd_cnt <= '0;
      r_ccd_cnt <= '0;
      r_wtr_cnt <= '0;
      r_rtw_cnt <= '0;
    end else begin
      if (w_cmd == CMD_ACT)                      r_rrd_cnt <= ld_val(t_rrd_i);
      else if (r_rrd_cnt != '0)                  r_rrd_cnt <= r_rrd_cnt - 1'b1;
      if (w_cmd == CMD_RD || w_cmd == CMD_WR)    r_ccd_cnt <= ld_val(t_ccd_i);
      else if (r_ccd_cnt != '0)                  r_ccd_cnt <= r_ccd_cnt - 1'b1;
      if (w_cmd == CMD_WR)                       r_wtr_cnt <= ld_val(t_wtr_i);
      else if (r_wtr_cnt != '0)                  r_wtr_cnt <= r_wtr_cnt - 1'b1;
      if (w_cmd == CMD_RD)                       r_rtw_cnt <= ld_val(t_rtw_i);
      else if (r_rtw_cnt != '0)                  r_rtw_cnt <= r_rtw_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      cmd_valid_o <= 1'b0;
      cmd_o       <= CMD_NOP;
      cmd_ba_o    <= '0;
      cmd_addr_o  <= '0;
    end else if (w_gnt) begin
      r_rr_ptr    <= w_bank + 1'b1;
      cmd_valid_o <= 1'b1;
      cmd_o       <= w_cmd;
      cmd_ba_o    <= w_bank;
      cmd_addr_o  <= w_addr;
    end else begin
      cmd_valid_o <= 1'b0;
      cmd_o       <= CMD_NOP;
    end
  end

endmodule
